// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game-state controller: state encodings,
// obstacle count, score width and score saturation value.
package game_ctrl_pkg;

  localparam int NUM_OBSTACLES = 2;
  localparam int SCORE_W       = 14;
  localparam int MAX_SCORE     = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } game_state_e;

endpackage

// File: rtl/game_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-high button followed by
// a rising-edge detector; rise is a one-clock pulse per press. Also used by
// the dino jump path.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the raw button and remember the previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: latches dino/obstacle overlap per frame, runs the
// IDLE/RUN/HIT/OVER machine on frame ticks and keeps score, speed level and
// (optionally) the high score.
// Optional feature macro: GAME_CTRL_HIGH_SCORE_EN enables the high-score
// register; when undefined o_hi_score is tied to zero.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int NUM_OBSTACLES = game_ctrl_pkg::NUM_OBSTACLES,
  parameter int SCORE_DIV     = 6,
  parameter int SPEED_STEP    = 100,
  parameter int HIT_FRAMES    = 30,
  parameter int MAX_SCORE     = game_ctrl_pkg::MAX_SCORE
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pix_stb,
  input  logic                     i_animate,
  input  logic                     i_jump_btn,
  input  logic                     i_dino_px,
  input  logic [NUM_OBSTACLES-1:0] i_obst_px,
  output logic [1:0]               o_state,
  output logic                     o_run,
  output logic                     o_collision,
  output logic [SCORE_W-1:0]       o_score,
  output logic [3:0]               o_speed,
  output logic [SCORE_W-1:0]       o_hi_score
);

  localparam logic [7:0]         FRAME_LAST = 8'(SCORE_DIV - 1);
  localparam logic [9:0]         STEP_LAST  = 10'(SPEED_STEP - 1);
  localparam logic [7:0]         HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         speed_q, speed_d;
  logic [7:0]         frame_q, frame_d;
  logic [9:0]         step_q, step_d;
  logic [7:0]         hit_q, hit_d;
  logic               coll_q, coll_d;
  logic               press_pend_q;
  logic               hit_flag_q;
  logic               press_rise;
  logic               frame_tick;
  logic               overlap;
  logic               eval_hit;

  btn_sync_edge u_btn (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .btn   (i_jump_btn),
    .rise  (press_rise)
  );

  assign frame_tick = i_pix_stb & i_animate;
  assign overlap    = i_pix_stb & i_dino_px & (|i_obst_px) & (state_q == ST_RUN);
  assign eval_hit   = hit_flag_q | overlap;

  // Remember a button press until the next frame tick consumes or drops it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        press_pend_q <= 1'b0;
    else if (frame_tick) press_pend_q <= 1'b0;
    else if (press_rise) press_pend_q <= 1'b1;
  end

  // Latch any overlap seen during the frame; every tick starts a fresh frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        hit_flag_q <= 1'b0;
    else if (frame_tick) hit_flag_q <= 1'b0;
    else if (overlap)    hit_flag_q <= 1'b1;
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      speed_q <= '0;
      frame_q <= '0;
      step_q  <= '0;
      hit_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      speed_q <= speed_d;
      frame_q <= frame_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
    end
  end

  // Next-state and counter logic, evaluated only on frame ticks
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    speed_d = speed_q;
    frame_d = frame_q;
    step_d  = step_q;
    hit_d   = hit_q;
    coll_d  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (press_pend_q) begin
            state_d = ST_RUN;
            score_d = '0;
            speed_d = '0;
            frame_d = '0;
            step_d  = '0;
          end
        end
        ST_RUN: begin
          if (eval_hit) begin
            state_d = ST_HIT;
            coll_d  = 1'b1;
            hit_d   = HIT_LAST;
          end else if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            if (score_q < SCORE_MAX) begin
              score_d = score_q + 1'b1;
              if (step_q == STEP_LAST) begin
                step_d = '0;
                if (speed_q != 4'hF) speed_d = speed_q + 1'b1;
              end else begin
                step_d = step_q + 1'b1;
              end
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        ST_HIT: begin
          if (hit_q == '0) state_d = ST_OVER;
          else             hit_d   = hit_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_state     = state_q;
  assign o_run       = (state_q == ST_RUN);
  assign o_collision = coll_q;
  assign o_score     = score_q;
  assign o_speed     = speed_q;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi_q;
  logic               hi_load;

  assign hi_load = frame_tick & (state_q == ST_HIT) & (hit_q == '0);

  // Capture a new best score as the game ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         hi_q <= '0;
    else if (hi_load && score_q > hi_q)   hi_q <= score_q;
  end

  assign o_hi_score = hi_q;
`else
  assign o_hi_score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a table of game steps with expected
// outputs, plus hand-written sequences for reset, score saturation and an
// asynchronous reset in mid-frame.
module tb_game_ctrl;

`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam int HI_ON = 1;
`else
  localparam int HI_ON = 0;
`endif

  typedef struct {
    string name;
    bit    press;
    int    frames;
    bit    ov_mid;
    bit    ov_tick;
    int    exp_state;
    int    exp_score;
    int    exp_speed;
    int    exp_hi;
    int    exp_coll;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix, anim, btn, dino;
  logic [1:0]  obst;
  logic [1:0]  state;
  logic        run, coll;
  logic [13:0] score, hi_score;
  logic [3:0]  speed;

  logic        pix2, anim2, btn2, dino2;
  logic [1:0]  obst2;
  logic [1:0]  state2;
  logic        run2, coll2;
  logic [13:0] score2, hi_score2;
  logic [3:0]  speed2;

  int checks   = 0;
  int failures = 0;
  int coll_cnt = 0;
  vec_t vecs[14];

  game_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix), .i_animate(anim),
    .i_jump_btn(btn), .i_dino_px(dino), .i_obst_px(obst),
    .o_state(state), .o_run(run), .o_collision(coll), .o_score(score),
    .o_speed(speed), .o_hi_score(hi_score)
  );

  game_ctrl #(.SCORE_DIV(1), .SPEED_STEP(1000)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix2), .i_animate(anim2),
    .i_jump_btn(btn2), .i_dino_px(dino2), .i_obst_px(obst2),
    .o_state(state2), .o_run(run2), .o_collision(coll2), .o_score(score2),
    .o_speed(speed2), .o_hi_score(hi_score2)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count collision pulses on the main instance, sampled away from the edge
  always @(negedge clk) begin
    if (coll === 1'b1) coll_cnt++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pressButton();
    @(negedge clk);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic runFrame(input bit ov_mid, input bit ov_tick);
    @(negedge clk);
    pix = 1'b1; anim = 1'b0; dino = ov_mid; obst = ov_mid ? 2'b10 : 2'b00;
    @(negedge clk);
    pix = 1'b0; dino = 1'b0; obst = 2'b00;
    @(negedge clk);
    pix = 1'b1; anim = 1'b1; dino = ov_tick; obst = ov_tick ? 2'b01 : 2'b00;
    @(negedge clk);
    pix = 1'b0; anim = 1'b0; dino = 1'b0; obst = 2'b00;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.press) pressButton();
    for (int f = 0; f < v.frames; f++) runFrame(v.ov_mid, v.ov_tick);
    @(negedge clk);
  endtask

  task automatic satTick();
    @(negedge clk);
    pix2 = 1'b1; anim2 = 1'b1;
    @(negedge clk);
    pix2 = 1'b0; anim2 = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".state"}, int'(state), 0);
    checkOutput({tag, ".run"},   int'(run),   0);
    checkOutput({tag, ".coll"},  int'(coll),  0);
    checkOutput({tag, ".score"}, int'(score), 0);
    checkOutput({tag, ".speed"}, int'(speed), 0);
    checkOutput({tag, ".hi"},    int'(hi_score), 0);
    checkOutput({tag, ".state2"}, int'(state2), 0);
  endtask

  // Main test sequence
  initial begin
    vecs[0]  = '{"idleOv",     1'b0,   2, 1'b1, 1'b1, 0,   0, 0, 0,         0};
    vecs[1]  = '{"start",      1'b1,   1, 1'b0, 1'b0, 1,   0, 0, 0,         0};
    vecs[2]  = '{"score600",   1'b0, 600, 1'b0, 1'b0, 1, 100, 1, 0,         0};
    vecs[3]  = '{"run5",       1'b0,   5, 1'b0, 1'b0, 1, 100, 1, 0,         0};
    vecs[4]  = '{"run1",       1'b0,   1, 1'b0, 1'b0, 1, 101, 1, 0,         0};
    vecs[5]  = '{"midHit",     1'b0,   1, 1'b1, 1'b0, 2, 101, 1, 0,         1};
    vecs[6]  = '{"hitPress29", 1'b1,  29, 1'b0, 1'b0, 2, 101, 1, 0,         1};
    vecs[7]  = '{"hitLast",    1'b0,   1, 1'b0, 1'b0, 3, 101, 1, 101*HI_ON, 1};
    vecs[8]  = '{"overOv",     1'b0,   3, 1'b1, 1'b1, 3, 101, 1, 101*HI_ON, 1};
    vecs[9]  = '{"restart",    1'b1,   1, 1'b0, 1'b0, 1,   0, 0, 101*HI_ON, 1};
    vecs[10] = '{"pressRun",   1'b1,   6, 1'b0, 1'b0, 1,   1, 0, 101*HI_ON, 1};
    vecs[11] = '{"run336",     1'b0, 336, 1'b0, 1'b0, 1,  57, 0, 101*HI_ON, 1};
    vecs[12] = '{"tickHit",    1'b0,   1, 1'b0, 1'b1, 2,  57, 0, 101*HI_ON, 2};
    vecs[13] = '{"hit30",      1'b0,  30, 1'b0, 1'b0, 3,  57, 0, 101*HI_ON, 2};

    rst_n = 1'b0;
    pix = 0; anim = 0; btn = 0; dino = 0; obst = 2'b00;
    pix2 = 0; anim2 = 0; btn2 = 0; dino2 = 0; obst2 = 2'b00;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, ".state"}, int'(state), vecs[i].exp_state);
      checkOutput({vecs[i].name, ".run"},   int'(run),   (vecs[i].exp_state == 1) ? 1 : 0);
      checkOutput({vecs[i].name, ".score"}, int'(score), vecs[i].exp_score);
      checkOutput({vecs[i].name, ".speed"}, int'(speed), vecs[i].exp_speed);
      checkOutput({vecs[i].name, ".hi"},    int'(hi_score), vecs[i].exp_hi);
      checkOutput({vecs[i].name, ".coll"},  coll_cnt,    vecs[i].exp_coll);
    end

    @(negedge clk);
    btn2 = 1'b1;
    repeat (5) @(negedge clk);
    btn2 = 1'b0;
    repeat (2) @(negedge clk);
    satTick();
    checkOutput("sat.start", int'(state2), 1);
    for (int i = 0; i < 9998; i++) satTick();
    checkOutput("sat.score9998", int'(score2), 9998);
    checkOutput("sat.speed9998", int'(speed2), 9);
    for (int i = 0; i < 12; i++) satTick();
    checkOutput("sat.score", int'(score2), 9999);
    checkOutput("sat.speed", int'(speed2), 9);
    checkOutput("sat.state", int'(state2), 1);

    pressButton();
    for (int f = 0; f < 7; f++) runFrame(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("preRst.score", int'(score), 1);
    checkOutput("preRst.state", int'(state), 1);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    pix = 1'b1; dino = 1'b1; obst = 2'b10;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midRst");
    pix = 1'b0; dino = 1'b0; obst = 2'b00; btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runFrame(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postRst.state", int'(state), 0);
    checkOutput("postRst.score", int'(score), 0);
    checkOutput("postRst.coll",  coll_cnt,    2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
